mac_operand_feeder: RTL

- Upstream feeder for the 8x8 multiply-accumulate unit.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues pairs on the MAC A/B inputs and drives the MAC clear input (reset_p) at the start of each vector.
- Pulses vec_done when the MAC output S holds the complete dot product of the vector.

---
 rtl/mac_operand_feeder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mac_operand_feeder.sv
// Operand feeder for an 8x8 multiply-accumulate unit: buffers {a,b,last} pairs in a
// small FIFO, clears the MAC at the start of each vector and flags when S is final.
module mac_operand_feeder #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4,
   parameter int MAC_LAT = 1
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_a,
   input  logic [DATA_W-1:0]          in_b,
   input  logic                       in_last,
   output logic                       in_ready,
   output logic [DATA_W-1:0]          mac_a,
   output logic [DATA_W-1:0]          mac_b,
   output logic                       mac_clear,
   output logic                       vec_done,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 2 * DATA_W + 1;

   typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

   logic [ENT_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mac_a_q, mac_a_d;
   logic [DATA_W-1:0] mac_b_q, mac_b_d;
   logic              mac_clear_q, mac_clear_d;
   logic              vec_done_q, vec_done_d;
   logic [2:0]        drain_q, drain_d;

   logic              push;
   logic              pop;
   logic              empty;
   logic [ENT_W-1:0]  head;
   logic [DATA_W-1:0] head_a;
   logic [DATA_W-1:0] head_b;
   logic              head_last;

   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign push      = in_valid && in_ready;
   assign empty     = (count_q == '0);
   assign head      = mem_q[rd_ptr_q];
   assign head_a    = head[ENT_W-1 -: DATA_W];
   assign head_b    = head[DATA_W:1];
   assign head_last = head[0];

   // Storage holds no reset: occupancy alone decides which entries are meaningful.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clock) begin
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
               mem_q[gi] <= {in_a, in_b, in_last};
            end
         end
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      mac_a_d     = '0;
      mac_b_d     = '0;
      mac_clear_d = 1'b0;
      vec_done_d  = 1'b0;
      drain_d     = drain_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               mac_clear_d = 1'b1;
               state_d     = CLEAR;
            end
         end
         CLEAR, STREAM: begin
            state_d = STREAM;
            if (!empty) begin
               pop     = 1'b1;
               mac_a_d = head_a;
               mac_b_d = head_b;
               // The final pair ends the vector; nothing further is issued until vec_done.
               if (head_last) begin
                  drain_d = 3'(MAC_LAT);
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            drain_d = drain_q - 3'd1;
            if (drain_q == 3'd1) begin
               vec_done_d = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= IDLE;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         mac_clear_q <= 1'b1;
         vec_done_q  <= 1'b0;
         drain_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         mac_clear_q <= mac_clear_d;
         vec_done_q  <= vec_done_d;
         drain_q     <= drain_d;
      end
   end

   assign mac_a      = mac_a_q;
   assign mac_b      = mac_b_q;
   assign mac_clear  = mac_clear_q;
   assign vec_done   = vec_done_q;
   assign busy       = (state_q != IDLE);
   assign fifo_count = count_q;

endmodule
